// File: rtl/udp_rx_parser.sv
// udp_rx_parser: GMII receive-side parser for Ethernet II / IPv4 / UDP frames.
// Strips preamble and headers, filters on board MAC/IP/port and streams the
// UDP payload out one byte per clock. Headers are assembled in a byte shift
// register and checked on the byte that completes each field.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// IDLE        | waiting for a fresh gmii_rx_dv rising edge with an 8'h55 byte
// PREAMBLE    | counting the remaining six 8'h55 bytes, then 8'hD5 (SFD)
// ETH_HEAD    | 14-byte MAC header: destination MAC filter, EtherType 0x0800
// IP_HEAD     | IPv4 header incl. options (IHL*4 bytes): protocol/dest IP filter
// UDP_HEAD    | 8-byte UDP header: destination port filter, length sanity
// RX_DATA     | streaming payload bytes out on rec_en/rec_data
// RX_END      | discarding the rest of the frame until gmii_rx_dv drops

module udp_rx_parser #(
   parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
   parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd123},
   parameter logic [15:0] BOARD_PORT = 16'd1234
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   output logic        rec_en,
   output logic [7:0]  rec_data,
   output logic        rec_pkt_done,
   output logic [15:0] rec_byte_num,
   output logic [47:0] src_mac,
   output logic [31:0] src_ip,
   output logic [15:0] src_port,
   output logic        rx_err
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_PREAMBLE = 3'd1;
   localparam logic [2:0] ST_ETH_HEAD = 3'd2;
   localparam logic [2:0] ST_IP_HEAD  = 3'd3;
   localparam logic [2:0] ST_UDP_HEAD = 3'd4;
   localparam logic [2:0] ST_RX_DATA  = 3'd5;
   localparam logic [2:0] ST_RX_END   = 3'd6;

   logic [2:0]  state;
   logic [15:0] cnt;
   logic        dv_d;
   logic [39:0] sh;
   logic [47:0] sh_next;
   logic [47:0] mac_tmp;
   logic [31:0] ip_tmp;
   logic [15:0] port_tmp;
   logic [3:0]  ihl;
   logic [15:0] data_len;
   logic [15:0] ip_last;
   logic        abort;
   logic        hdr_bad;

   // sh_next always holds the last six bytes including the current one, so a
   // field ending on this byte is available without waiting a cycle.
   assign sh_next = {sh, gmii_rxd};
   assign ip_last = {10'd0, ihl, 2'b00} - 16'd1;
   assign abort   = !gmii_rx_dv && (state inside {ST_PREAMBLE, ST_ETH_HEAD, ST_IP_HEAD,
                                                 ST_UDP_HEAD, ST_RX_DATA});

   // Field checks evaluated on the byte that completes each filtered field.
   always_comb begin
      hdr_bad = 1'b0;
      case (state)
         ST_PREAMBLE: hdr_bad = (cnt < 16'd6) ? (gmii_rxd != 8'h55) : (gmii_rxd != 8'hD5);
         ST_ETH_HEAD: begin
            if (cnt == 16'd5)
               hdr_bad = (sh_next != BOARD_MAC) && (sh_next != 48'hFF_FF_FF_FF_FF_FF);
            else if (cnt == 16'd13)
               hdr_bad = (sh_next[15:0] != 16'h0800);
         end
         ST_IP_HEAD: begin
            if (cnt == 16'd0)
               hdr_bad = (gmii_rxd[3:0] < 4'd5);
            else if (cnt == 16'd9)
               hdr_bad = (gmii_rxd != 8'd17);
            else if (cnt == 16'd19)
               hdr_bad = (sh_next[31:0] != BOARD_IP);
         end
         ST_UDP_HEAD: begin
            if (cnt == 16'd3)
               hdr_bad = (sh_next[15:0] != BOARD_PORT);
            else if (cnt == 16'd5)
               hdr_bad = (sh_next[15:0] < 16'd8);
         end
         default: hdr_bad = 1'b0;
      endcase
   end

   // Previous dv; reset to 1 so a frame interrupted by reset is not picked up
   // mid-stream and IDLE only starts on a genuine dv rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dv_d <= 1'b1;
      else        dv_d <= gmii_rx_dv;
   end

   // Frame FSM, header capture and payload output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= 16'd0;
         sh           <= 40'd0;
         mac_tmp      <= 48'd0;
         ip_tmp       <= 32'd0;
         port_tmp     <= 16'd0;
         ihl          <= 4'd0;
         data_len     <= 16'd0;
         rec_en       <= 1'b0;
         rec_data     <= 8'h00;
         rec_pkt_done <= 1'b0;
         rec_byte_num <= 16'd0;
         src_mac      <= 48'd0;
         src_ip       <= 32'd0;
         src_port     <= 16'd0;
         rx_err       <= 1'b0;
      end else begin
         rec_en       <= 1'b0;
         rec_pkt_done <= 1'b0;
         rx_err       <= 1'b0;
         if (gmii_rx_dv) sh <= sh_next[39:0];

         if (abort) begin
            state  <= ST_IDLE;
            cnt    <= 16'd0;
            rx_err <= 1'b1;
         end else if (hdr_bad) begin
            state  <= ST_RX_END;
            cnt    <= 16'd0;
            rx_err <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (gmii_rx_dv && !dv_d && gmii_rxd == 8'h55) begin
                     state <= ST_PREAMBLE;
                     cnt   <= 16'd0;
                  end
               end
               ST_PREAMBLE: begin
                  if (cnt == 16'd6) begin
                     state <= ST_ETH_HEAD;
                     cnt   <= 16'd0;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               ST_ETH_HEAD: begin
                  if (cnt == 16'd11) mac_tmp <= sh_next;
                  if (cnt == 16'd13) begin
                     state <= ST_IP_HEAD;
                     cnt   <= 16'd0;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               ST_IP_HEAD: begin
                  if (cnt == 16'd0)  ihl    <= gmii_rxd[3:0];
                  if (cnt == 16'd15) ip_tmp <= sh_next[31:0];
                  if (cnt != 16'd0 && cnt == ip_last) begin
                     state <= ST_UDP_HEAD;
                     cnt   <= 16'd0;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               ST_UDP_HEAD: begin
                  if (cnt == 16'd1) port_tmp <= sh_next[15:0];
                  if (cnt == 16'd5) data_len <= sh_next[15:0] - 16'd8;
                  if (cnt == 16'd7) begin
                     cnt <= 16'd0;
                     if (data_len == 16'd0) begin
                        rec_pkt_done <= 1'b1;
                        rec_byte_num <= 16'd0;
                        src_mac      <= mac_tmp;
                        src_ip       <= ip_tmp;
                        src_port     <= port_tmp;
                        state        <= ST_RX_END;
                     end else begin
                        state <= ST_RX_DATA;
                     end
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               ST_RX_DATA: begin
                  rec_en   <= 1'b1;
                  rec_data <= gmii_rxd;
                  if (cnt == data_len - 16'd1) begin
                     rec_pkt_done <= 1'b1;
                     rec_byte_num <= data_len;
                     src_mac      <= mac_tmp;
                     src_ip       <= ip_tmp;
                     src_port     <= port_tmp;
                     state        <= ST_RX_END;
                     cnt          <= 16'd0;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               ST_RX_END: begin
                  if (!gmii_rx_dv) state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
                  cnt   <= 16'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Bench for udp_rx_parser: a vector table of whole frames, hand-built
// multi-frame sequences (abort + back-to-back, reset mid-frame) and random
// frames checked against a frame-level acceptance model.

module tb_udp_rx_parser;

   localparam logic [47:0] BMAC  = 48'h00_11_22_33_44_55;
   localparam logic [31:0] BIP   = {8'd192, 8'd168, 8'd1, 8'd123};
   localparam logic [15:0] BPORT = 16'd1234;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gmii_rx_dv = 1'b0;
   logic [7:0]  gmii_rxd = 8'h00;
   logic        rec_en;
   logic [7:0]  rec_data;
   logic        rec_pkt_done;
   logic [15:0] rec_byte_num;
   logic [47:0] src_mac;
   logic [31:0] src_ip;
   logic [15:0] src_port;
   logic        rx_err;

   udp_rx_parser #(.BOARD_MAC(BMAC), .BOARD_IP(BIP), .BOARD_PORT(BPORT)) dut (
      .clk(clk), .rst_n(rst_n), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
      .rec_en(rec_en), .rec_data(rec_data), .rec_pkt_done(rec_pkt_done),
      .rec_byte_num(rec_byte_num), .src_mac(src_mac), .src_ip(src_ip),
      .src_port(src_port), .rx_err(rx_err)
   );

   always #4 clk = ~clk;

   typedef struct {
      logic [47:0] dmac, smac;
      logic [15:0] etype;
      logic [3:0]  ihl;
      logic [7:0]  proto;
      logic [31:0] sip, dip;
      logic [15:0] sport, dport;
      int          plen;
      bit          ulen_bad;
      int          pad;
      int          bad_pre;
      int          cut;
      logic [7:0]  pseed, pstep;
      bit          exp_done;
      int          exp_n;
      bit          exp_err;
   } vec_t;

   typedef logic [7:0] bq_t[$];

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  mon_q[$];
   int          n_done = 0;
   int          n_err  = 0;
   int          n_ovl  = 0;
   int          done_pos = 0;
   logic        done_en = 1'b0;

   logic [47:0] last_mac  = 48'd0;
   logic [31:0] last_ip   = 32'd0;
   logic [15:0] last_port = 16'd0;
   logic [15:0] last_n    = 16'd0;

   // Output monitor: only ever appends, the checker works on deltas.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rec_en) mon_q.push_back(rec_data);
         if (rec_pkt_done) begin
            n_done   <= n_done + 1;
            done_pos <= mon_q.size();
            done_en  <= rec_en;
         end
         if (rx_err) n_err <= n_err + 1;
         if (rx_err && rec_pkt_done) n_ovl <= n_ovl + 1;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached, got no summary, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] pbyte(input vec_t v, input int i);
      return v.pseed + v.pstep * 8'(i);
   endfunction

   function automatic vec_t mk(input logic [47:0] dmac, input logic [15:0] etype,
                               input logic [7:0] proto, input logic [31:0] dip,
                               input logic [15:0] dport, input logic [3:0] ihl,
                               input int plen, input int pad, input int bad_pre,
                               input bit ulen_bad, input bit edone, input int en);
      vec_t v;
      v.dmac = dmac; v.etype = etype; v.proto = proto; v.dip = dip; v.dport = dport;
      v.ihl = ihl; v.plen = plen; v.pad = pad; v.bad_pre = bad_pre; v.ulen_bad = ulen_bad;
      v.smac  = 48'hA0_B0_C0_00_00_00 | 48'($urandom_range(1, 255));
      v.sip   = {8'd10, 8'd0, 8'd0, 8'($urandom_range(1, 254))};
      v.sport = 16'($urandom_range(1024, 65535));
      v.cut = -1; v.pseed = 8'h11; v.pstep = 8'h11;
      v.exp_done = edone; v.exp_n = en; v.exp_err = !edone;
      return v;
   endfunction

   // Serialise a frame: preamble/SFD, MAC, IPv4 (+options), UDP, payload, pad, FCS.
   function automatic void build(input vec_t v, output bq_t q);
      logic [15:0] ul, tot;
      int hl;
      q = {};
      for (int i = 0; i < 7; i++) q.push_back(8'h55);
      q.push_back(8'hD5);
      if (v.bad_pre >= 0) q[v.bad_pre] = 8'h54;
      for (int i = 5; i >= 0; i--) q.push_back(v.dmac[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) q.push_back(v.smac[i*8 +: 8]);
      q.push_back(v.etype[15:8]); q.push_back(v.etype[7:0]);
      hl  = int'(v.ihl) * 4;
      ul  = v.ulen_bad ? 16'd7 : 16'(v.plen + 8);
      tot = 16'(hl) + ul;
      q.push_back({4'h4, v.ihl}); q.push_back(8'h00);
      q.push_back(tot[15:8]); q.push_back(tot[7:0]);
      for (int i = 0; i < 4; i++) q.push_back(8'h00);
      q.push_back(8'h40); q.push_back(v.proto);
      q.push_back(8'h00); q.push_back(8'h00);
      for (int i = 3; i >= 0; i--) q.push_back(v.sip[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) q.push_back(v.dip[i*8 +: 8]);
      for (int i = 20; i < hl; i++) q.push_back(8'hA5);
      q.push_back(v.sport[15:8]); q.push_back(v.sport[7:0]);
      q.push_back(v.dport[15:8]); q.push_back(v.dport[7:0]);
      q.push_back(ul[15:8]); q.push_back(ul[7:0]);
      q.push_back(8'h00); q.push_back(8'h00);
      if (v.cut >= 0 && v.cut < v.plen) begin
         for (int i = 0; i < v.cut; i++) q.push_back(pbyte(v, i));
      end else begin
         for (int i = 0; i < v.plen; i++) q.push_back(pbyte(v, i));
         for (int i = 0; i < v.pad; i++) q.push_back(8'($urandom));
         for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
      end
   endfunction

   // Frame-level acceptance rules.
   function automatic void model(input vec_t v, output bit done, output int n, output bit err);
      bit ok;
      ok = (v.bad_pre < 0) && (v.dmac == BMAC || v.dmac == BCAST) && (v.etype == 16'h0800)
           && (v.ihl >= 4'd5) && (v.proto == 8'd17) && (v.dip == BIP)
           && (v.dport == BPORT) && !v.ulen_bad;
      if (!ok) begin
         done = 1'b0; n = 0; err = 1'b1;
      end else if (v.cut >= 0 && v.cut < v.plen) begin
         done = 1'b0; n = v.cut; err = 1'b1;
      end else begin
         done = 1'b1; n = v.plen; err = 1'b0;
      end
   endfunction

   task automatic send(input bq_t fr, input int rst_at);
      for (int i = 0; i < fr.size(); i++) begin
         @(negedge clk);
         gmii_rx_dv = 1'b1;
         gmii_rxd   = fr[i];
         if (i == rst_at)     rst_n = 1'b0;
         if (i == rst_at + 2) rst_n = 1'b1;
      end
      @(negedge clk);
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'h00;
   endtask

   task automatic check_held(input string tag);
      chk({tag, "/rec_byte_num"}, 64'(rec_byte_num), 64'(last_n));
      chk({tag, "/src_mac"},      64'(src_mac),      64'(last_mac));
      chk({tag, "/src_ip"},       64'(src_ip),       64'(last_ip));
      chk({tag, "/src_port"},     64'(src_port),     64'(last_port));
   endtask

   task automatic run(input vec_t v, input string tag, input bit edone, input int en, input bit eerr);
      bq_t fr;
      int  b_q, b_done, b_err, mism;
      build(v, fr);
      b_q = mon_q.size(); b_done = n_done; b_err = n_err;
      send(fr, -10);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "/n_bytes"}, 64'(mon_q.size() - b_q), 64'(en));
      mism = 0;
      for (int i = 0; i < en && b_q + i < mon_q.size(); i++)
         if (mon_q[b_q + i] !== pbyte(v, i)) mism++;
      chk({tag, "/payload_mismatches"}, 64'(mism), 64'd0);
      chk({tag, "/done_pulses"}, 64'(n_done - b_done), 64'(edone));
      chk({tag, "/err_pulses"},  64'(n_err - b_err),   64'(eerr));
      if (edone) begin
         last_mac = v.smac; last_ip = v.sip; last_port = v.sport; last_n = 16'(en);
         chk({tag, "/done_at_byte"}, 64'(done_pos - b_q), 64'(en));
         chk({tag, "/done_with_en"}, 64'(done_en), 64'(en > 0));
      end
      check_held(tag);
   endtask

   vec_t tbl[14];

   initial begin
      vec_t v, v2;
      bq_t  f1, f2;
      bit   edone, eerr;
      int   en, b_q, b_done, b_err, mism;

      tbl[0]  = mk(BMAC, 16'h0800, 8'd17, BIP, BPORT, 4'd5, 4, 14, -1, 1'b0, 1'b1, 4);
      tbl[1]  = mk(BCAST, 16'h0800, 8'd17, BIP, BPORT, 4'd5, 1, 17, -1, 1'b0, 1'b1, 1);
      tbl[2]  = mk(BMAC, 16'h0800, 8'd17, {8'd192, 8'd168, 8'd1, 8'd200}, BPORT, 4'd5, 4, 0, -1, 1'b0, 1'b0, 0);
      tbl[3]  = mk(BMAC, 16'h0800, 8'd17, BIP, BPORT, 4'd6, 2, 10, -1, 1'b0, 1'b1, 2);
      tbl[4]  = mk(BMAC, 16'h0800, 8'd17, BIP, BPORT, 4'd5, 4, 0, 3, 1'b0, 1'b0, 0);
      tbl[5]  = mk(48'h00_11_22_33_44_56, 16'h0800, 8'd17, BIP, BPORT, 4'd5, 4, 0, -1, 1'b0, 1'b0, 0);
      tbl[6]  = mk(BMAC, 16'h86DD, 8'd17, BIP, BPORT, 4'd5, 4, 0, -1, 1'b0, 1'b0, 0);
      tbl[7]  = mk(BMAC, 16'h0800, 8'd6, BIP, BPORT, 4'd5, 4, 0, -1, 1'b0, 1'b0, 0);
      tbl[8]  = mk(BMAC, 16'h0800, 8'd17, BIP, 16'd1235, 4'd5, 4, 0, -1, 1'b0, 1'b0, 0);
      tbl[9]  = mk(BMAC, 16'h0800, 8'd17, BIP, BPORT, 4'd5, 0, 6, -1, 1'b1, 1'b0, 0);
      tbl[10] = mk(BMAC, 16'h0800, 8'd17, BIP, BPORT, 4'd5, 0, 18, -1, 1'b0, 1'b1, 0);
      tbl[11] = mk(BMAC, 16'h0800, 8'd17, BIP, BPORT, 4'd15, 3, 5, -1, 1'b0, 1'b1, 3);
      tbl[12] = mk(BMAC, 16'h0800, 8'd17, BIP, BPORT, 4'd5, 300, 0, -1, 1'b0, 1'b1, 300);
      tbl[13] = mk(48'h01_00_5E_00_00_01, 16'h0800, 8'd17, BIP, BPORT, 4'd5, 4, 0, -1, 1'b0, 1'b0, 0);

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      chk("reset/rec_en",       64'(rec_en),       64'd0);
      chk("reset/rec_pkt_done", 64'(rec_pkt_done), 64'd0);
      chk("reset/rx_err",       64'(rx_err),       64'd0);
      chk("reset/rec_data",     64'(rec_data),     64'd0);
      check_held("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      for (int i = 0; i < 14; i++)
         run(tbl[i], $sformatf("tbl%0d", i), tbl[i].exp_done, tbl[i].exp_n, tbl[i].exp_err);

      // dv drops after 3 of 10 payload bytes, a valid frame follows one idle cycle later.
      v = mk(BMAC, 16'h0800, 8'd17, BIP, BPORT, 4'd5, 10, 0, -1, 1'b0, 1'b0, 3);
      v.cut = 3;
      v2 = mk(BMAC, 16'h0800, 8'd17, BIP, BPORT, 4'd5, 5, 8, -1, 1'b0, 1'b1, 5);
      v2.pseed = 8'h3C; v2.pstep = 8'h07;
      build(v, f1);
      build(v2, f2);
      b_q = mon_q.size(); b_done = n_done; b_err = n_err;
      send(f1, -10);
      send(f2, -10);
      repeat (4) @(posedge clk);
      #1;
      chk("b2b/n_bytes", 64'(mon_q.size() - b_q), 64'd8);
      mism = 0;
      for (int i = 0; i < 8 && b_q + i < mon_q.size(); i++)
         if (mon_q[b_q + i] !== ((i < 3) ? pbyte(v, i) : pbyte(v2, i - 3))) mism++;
      chk("b2b/payload_mismatches", 64'(mism), 64'd0);
      chk("b2b/done_pulses", 64'(n_done - b_done), 64'd1);
      chk("b2b/err_pulses",  64'(n_err - b_err),   64'd1);
      chk("b2b/done_at_byte", 64'(done_pos - b_q), 64'd8);
      last_mac = v2.smac; last_ip = v2.sip; last_port = v2.sport; last_n = 16'd5;
      check_held("b2b");

      // Reset during the MAC header while dv stays high: rest of frame ignored.
      v = mk(BMAC, 16'h0800, 8'd17, BIP, BPORT, 4'd5, 6, 0, -1, 1'b0, 1'b0, 0);
      build(v, f1);
      b_q = mon_q.size(); b_done = n_done; b_err = n_err;
      send(f1, 20);
      repeat (4) @(posedge clk);
      #1;
      chk("rst_mid/n_bytes",     64'(mon_q.size() - b_q), 64'd0);
      chk("rst_mid/done_pulses", 64'(n_done - b_done),    64'd0);
      chk("rst_mid/err_pulses",  64'(n_err - b_err),      64'd0);
      last_mac = 48'd0; last_ip = 32'd0; last_port = 16'd0; last_n = 16'd0;
      check_held("rst_mid");
      run(tbl[0], "after_rst", 1'b1, 4, 1'b0);

      // Random frames against the acceptance model.
      for (int k = 0; k < 30; k++) begin
         v = mk(BMAC, 16'h0800, 8'd17, BIP, BPORT, 4'd5, 0, 0, -1, 1'b0, 1'b0, 0);
         case ($urandom_range(0, 9))
            0, 1:    v.dmac = BCAST;
            2:       v.dmac = {16'($urandom), 32'($urandom)};
            default: v.dmac = BMAC;
         endcase
         v.smac  = {16'($urandom), 32'($urandom)};
         v.etype = ($urandom_range(0, 9) == 0) ? 16'h86DD : 16'h0800;
         v.ihl   = 4'($urandom_range(5, 8));
         v.proto = ($urandom_range(0, 9) == 0) ? 8'd6 : 8'd17;
         v.sip   = 32'($urandom);
         v.dip   = ($urandom_range(0, 9) == 0) ? (BIP ^ (32'h1 << $urandom_range(0, 31))) : BIP;
         v.sport = 16'($urandom);
         v.dport = ($urandom_range(0, 9) == 0) ? BPORT + 16'd1 : BPORT;
         v.plen  = int'($urandom_range(0, 40));
         v.ulen_bad = ($urandom_range(0, 19) == 0);
         if (v.ulen_bad) v.plen = 0;
         v.pad   = int'($urandom_range(0, 20));
         v.bad_pre = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 7)) : -1;
         v.cut   = (v.plen > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, v.plen - 1)) : -1;
         v.pseed = 8'($urandom);
         v.pstep = 8'($urandom);
         model(v, edone, en, eerr);
         run(v, $sformatf("rnd%0d", k), edone, en, eerr);
      end

      chk("err_done_overlap", 64'(n_ovl), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
